sample_capture_sequencer: RTL

// Sequences acquisition of the six 8-bit analog channels into an on-chip frame buffer for the Nios II section.

---
 rtl/sample_capture_pkg.sv | 28 ++
 rtl/sample_buffer_ram.sv | 41 ++++
 rtl/sample_capture_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_capture_pkg.sv
// ----------------------------------------------------------------------------
// sample_capture_pkg
// Shared types and constants for the sample capture sequencer.
//   state_t        : sequencer states (IDLE, ARM, CAPTURE, DONE)
//   CH_COUNT       : number of analog channels captured per sample set
//   CH_W           : bits per channel sample
//   WORD_W         : width of one packed sample set {ch6,...,ch1}
//   state_is_running : true while the sample tick divider is active
// ----------------------------------------------------------------------------
package sample_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int CH_COUNT = 6;
    localparam int CH_W     = 8;
    localparam int WORD_W   = CH_COUNT * CH_W;

    // The tick divider and capture_busy are both tied to these two states.
    function automatic logic state_is_running(input state_t s);
        return (s == ARM) || (s == CAPTURE);
    endfunction

endpackage

// File: rtl/sample_buffer_ram.sv
// ----------------------------------------------------------------------------
// sample_buffer_ram
// Simple dual-port frame buffer: one write port, one registered read port.
// The storage array has no reset so it maps onto block RAM.
//   i_clk      in   1       clock
//   i_wr_en    in   1       write strobe
//   i_wr_addr  in   ADDR_W  write address
//   i_wr_data  in   WORD_W  write data
//   i_rd_en    in   1       read strobe (updates o_rd_data next cycle)
//   i_rd_addr  in   ADDR_W  read address
//   o_rd_data  out  WORD_W  registered read data
// ----------------------------------------------------------------------------
module sample_buffer_ram #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int WORD_W = 48
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sample_capture_sequencer.sv
// ----------------------------------------------------------------------------
// sample_capture_sequencer
// Paces sampling of six 8-bit channels, aligns each frame to a rising
// crossing of channel 1 (or a forced capture after a timeout), fills a
// DEPTH-entry frame buffer, then serves CPU reads until the last address
// has been delivered, after which it re-arms.
//   clk_clk              in   1       system clock
//   reset_reset_n        in   1       asynchronous active-low reset
//   enable               in   1       1 = run, 0 = abort to IDLE
//   channel1..6_analog   in   8       channel samples (clk_clk synchronous)
//   read_address         in   ADDR_W  CPU read pointer
//   read_data            out  48      {ch6,...,ch1} of the served address
//   read_new_sample      out  1       one-cycle pulse, read_data valid
//   writing_finish_flag  out  1       frame complete and readable
//   capture_busy         out  1       state is ARM or CAPTURE
//   trig_timeout         out  1       current frame was force-captured
// ----------------------------------------------------------------------------
module sample_capture_sequencer
    import sample_capture_pkg::*;
#(
    parameter int DEPTH        = 4096,
    parameter int ADDR_W       = 12,
    parameter int SAMPLE_DIV   = 1000,
    parameter int TRIG_LEVEL   = 128,
    parameter int TRIG_TIMEOUT = 4096
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              enable,
    input  logic [7:0]        channel1_analog,
    input  logic [7:0]        channel2_analog,
    input  logic [7:0]        channel3_analog,
    input  logic [7:0]        channel4_analog,
    input  logic [7:0]        channel5_analog,
    input  logic [7:0]        channel6_analog,
    input  logic [ADDR_W-1:0] read_address,
    output logic [47:0]       read_data,
    output logic              read_new_sample,
    output logic              writing_finish_flag,
    output logic              capture_busy,
    output logic              trig_timeout
);

    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TO_W   = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TRIG_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   TRIG_LVL  = CH_W'(TRIG_LEVEL);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [CH_W-1:0]     r_prev1;
    logic                r_prev_valid;   // prev1 holds a real sample of this arm period
    logic                r_first_done;   // first cycle in DONE forces a read issue
    logic [ADDR_W-1:0]   r_ra_q;
    logic                r_rd_v1;        // read issued last cycle, RAM output valid now
    logic                r_rd_last1;     // ... and it targeted the last address
    logic                r_pulse;
    logic                r_pulse_last;
    logic [WORD_W-1:0]   r_read_data;
    logic                r_finish;
    logic                r_busy;
    logic                r_timeout;

    // ------------------------------------------------------------------
    // Sample packing {ch6,...,ch1}
    // ------------------------------------------------------------------
    logic [CH_W-1:0]     w_chan [CH_COUNT];
    logic [WORD_W-1:0]   w_sample;

    assign w_chan[0] = channel1_analog;
    assign w_chan[1] = channel2_analog;
    assign w_chan[2] = channel3_analog;
    assign w_chan[3] = channel4_analog;
    assign w_chan[4] = channel5_analog;
    assign w_chan[5] = channel6_analog;

    generate
        for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_pack
            assign w_sample[gi*CH_W +: CH_W] = w_chan[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                w_run;
    logic                w_tick;
    logic                w_cross;
    logic                w_start;
    logic                w_wr_en;
    logic                w_issue;
    logic                w_release;
    logic [WORD_W-1:0]   w_ram_q;

    assign w_run   = state_is_running(r_state);
    assign w_tick  = w_run && (r_tick_cnt == TICK_LAST);

    // Crossing needs a previous sample from the current arm period.
    assign w_cross = r_prev_valid && (r_prev1 < TRIG_LVL) && (channel1_analog >= TRIG_LVL);
    assign w_start = w_cross || (r_to_cnt == TO_LAST);

    // In ARM the write pointer is held at 0, so the trigger sample lands at address 0.
    assign w_wr_en = w_tick && (((r_state == ARM) && w_start) || (r_state == CAPTURE));

    assign w_issue   = (r_state == DONE) && (r_first_done || (read_address != r_ra_q));
    assign w_release = (r_state == DONE) && r_pulse && r_pulse_last;

    sample_buffer_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .i_clk     (clk_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_sample),
        .i_rd_en   (w_issue),
        .i_rd_addr (read_address),
        .o_rd_data (w_ram_q)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_to_cnt     <= '0;
            r_wr_ptr     <= '0;
            r_prev1      <= '0;
            r_prev_valid <= 1'b0;
            r_first_done <= 1'b0;
            r_ra_q       <= '0;
            r_rd_v1      <= 1'b0;
            r_rd_last1   <= 1'b0;
            r_pulse      <= 1'b0;
            r_pulse_last <= 1'b0;
            r_read_data  <= '0;
            r_finish     <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_ra_q       <= read_address;
            r_first_done <= 1'b0;
            // Read pipeline only advances in DONE; elsewhere it is flushed.
            r_rd_v1      <= 1'b0;
            r_rd_last1   <= 1'b0;
            r_pulse      <= 1'b0;
            r_pulse_last <= 1'b0;

            if (!enable) begin
                r_state      <= IDLE;
                r_tick_cnt   <= '0;
                r_to_cnt     <= '0;
                r_wr_ptr     <= '0;
                r_prev_valid <= 1'b0;
                r_finish     <= 1'b0;
                r_busy       <= 1'b0;
                r_timeout    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state      <= ARM;
                        r_busy       <= 1'b1;
                        r_tick_cnt   <= '0;
                        r_to_cnt     <= '0;
                        r_wr_ptr     <= '0;
                        r_prev_valid <= 1'b0;
                        r_timeout    <= 1'b0;
                    end

                    ARM: begin
                        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                        if (w_tick) begin
                            r_prev1      <= channel1_analog;
                            r_prev_valid <= 1'b1;
                            if (w_start) begin
                                r_state   <= CAPTURE;
                                r_wr_ptr  <= ADDR_W'(1);
                                // A genuine crossing wins over a coincident timeout.
                                r_timeout <= !w_cross;
                            end else begin
                                r_to_cnt <= r_to_cnt + 1'b1;
                            end
                        end
                    end

                    CAPTURE: begin
                        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                        if (w_tick) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;   // wraps to 0 after the last write
                            if (r_wr_ptr == ADDR_LAST) begin
                                r_state      <= DONE;
                                r_finish     <= 1'b1;
                                r_busy       <= 1'b0;
                                r_first_done <= 1'b1;
                                r_tick_cnt   <= '0;
                            end
                        end
                    end

                    DONE: begin
                        if (w_release) begin
                            // Pending issues are simply not carried into ARM.
                            r_state      <= ARM;
                            r_finish     <= 1'b0;
                            r_busy       <= 1'b1;
                            r_tick_cnt   <= '0;
                            r_to_cnt     <= '0;
                            r_wr_ptr     <= '0;
                            r_prev_valid <= 1'b0;
                            r_timeout    <= 1'b0;
                        end else begin
                            r_rd_v1      <= w_issue;
                            r_rd_last1   <= w_issue && (read_address == ADDR_LAST);
                            r_pulse      <= r_rd_v1;
                            r_pulse_last <= r_rd_last1;
                            if (r_rd_v1) begin
                                r_read_data <= w_ram_q;
                            end
                        end
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign read_data           = r_read_data;
    assign read_new_sample     = r_pulse;
    assign writing_finish_flag = r_finish;
    assign capture_busy        = r_busy;
    assign trig_timeout        = r_timeout;

endmodule
